// File: rtl/miriscv_timer_if.sv
// Bus and interrupt handshake signals of the miriscv timer peripheral.
// The master side is the core plus the interrupt controller; the slave side is the timer.
interface miriscv_timer_if;
  logic        req_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        int_req_o;
  logic        int_fin_i;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i, int_fin_i,
    input  rdata_o, int_req_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i, int_fin_i,
    output rdata_o, int_req_o
  );
endinterface

// File: rtl/miriscv_timer.sv
// Memory-mapped prescaled timer with compare match, sticky status and an
// interrupt request held until the controller returns the finish pulse.
//
// state | meaning
// IDLE  | no request outstanding, int_req_o low
// REQ   | request raised, waiting for int_fin_i
module miriscv_timer #(
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  miriscv_timer_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} irq_state_e;

  localparam logic [2:0] OFS_CTRL     = 3'd0;
  localparam logic [2:0] OFS_PRESCALE = 3'd1;
  localparam logic [2:0] OFS_COMPARE  = 3'd2;
  localparam logic [2:0] OFS_COUNT    = 3'd3;
  localparam logic [2:0] OFS_STATUS   = 3'd4;

  logic [2:0]  ctrl;
  logic [15:0] prescale;
  logic [31:0] compare;
  logic [31:0] count;
  logic [15:0] presc_cnt;
  logic        match_flag;
  logic        overrun_flag;
  logic [31:0] rdata_q;

  irq_state_e  state_q, state_d;
  logic        queued_q, queued_d;
  logic        set_overrun;

  logic        wr, rd;
  logic [2:0]  sel;
  logic        wr_ctrl, wr_prescale, wr_compare, wr_count, w1c;
  logic        en, auto_reload, irq_en;
  logic        tick, match, irq_event;
  logic [31:0] rd_val;
  logic        unused_addr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
    return res;
  endfunction

  assign unused_addr = ^{bus.addr_i[31:5], bus.addr_i[1:0]};

  assign wr  = bus.req_i & bus.we_i;
  assign rd  = bus.req_i & ~bus.we_i;
  assign sel = bus.addr_i[4:2];

  assign wr_ctrl     = wr && (sel == OFS_CTRL);
  assign wr_prescale = wr && (sel == OFS_PRESCALE);
  assign wr_compare  = wr && (sel == OFS_COMPARE);
  assign wr_count    = wr && (sel == OFS_COUNT);
  assign w1c         = wr && (sel == OFS_STATUS) && bus.be_i[0];

  assign en          = ctrl[0];
  assign auto_reload = ctrl[1];
  assign irq_en      = ctrl[2];

  // A COUNT write suppresses the tick's match; compare uses the pre-write COMPARE.
  assign tick      = en && (presc_cnt == prescale);
  assign match     = tick && !wr_count && (count == compare);
  assign irq_event = match && irq_en;

  always_comb begin
    state_d     = state_q;
    queued_d    = 1'b0;
    set_overrun = 1'b0;
    case (state_q)
      IDLE: begin
        if (irq_event || queued_q) state_d = REQ;
      end
      REQ: begin
        if (bus.int_fin_i) begin
          state_d  = IDLE;
          queued_d = irq_event;
        end else if (irq_event) begin
          set_overrun = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      queued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      queued_q <= queued_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl     <= 3'b000;
      prescale <= 16'h0000;
      compare  <= RESET_COMPARE;
    end else begin
      if (wr_ctrl && bus.be_i[0]) ctrl <= bus.wdata_i[2:0];
      if (wr_prescale) begin
        if (bus.be_i[0]) prescale[7:0]  <= bus.wdata_i[7:0];
        if (bus.be_i[1]) prescale[15:8] <= bus.wdata_i[15:8];
      end
      if (wr_compare) compare <= merge_bytes(compare, bus.wdata_i, bus.be_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count     <= 32'h0;
      presc_cnt <= 16'h0;
    end else begin
      if (wr_count || !en || tick) presc_cnt <= 16'h0;
      else                         presc_cnt <= presc_cnt + 16'd1;

      if (wr_count)                  count <= merge_bytes(count, bus.wdata_i, bus.be_i);
      else if (match && auto_reload) count <= 32'h0;
      else if (tick)                 count <= count + 32'd1;
    end
  end

  // Setting a sticky flag takes priority over a same-cycle clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      match_flag   <= 1'b0;
      overrun_flag <= 1'b0;
    end else begin
      if (match)                       match_flag <= 1'b1;
      else if (w1c && bus.wdata_i[0])  match_flag <= 1'b0;
      if (set_overrun)                 overrun_flag <= 1'b1;
      else if (w1c && bus.wdata_i[2])  overrun_flag <= 1'b0;
    end
  end

  always_comb begin
    rd_val = 32'h0;
    case (sel)
      OFS_CTRL:     rd_val = {29'h0, ctrl};
      OFS_PRESCALE: rd_val = {16'h0, prescale};
      OFS_COMPARE:  rd_val = compare;
      OFS_COUNT:    rd_val = count;
      OFS_STATUS:   rd_val = {29'h0, overrun_flag, (state_q == REQ), match_flag};
      default:      rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)   rdata_q <= 32'h0;
    else if (rd) rdata_q <= rd_val;
  end

  assign bus.rdata_o   = rdata_q;
  assign bus.int_req_o = (state_q == REQ);

endmodule

// File: tb/tb_miriscv_timer.sv
// Directed self-checking bench for miriscv_timer: register access, periodic
// and overrun interrupts, finish/event collision and asynchronous reset.
module tb_miriscv_timer;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;

  miriscv_timer_if bus ();

  miriscv_timer #(.RESET_COMPARE(32'hFFFF_FFFF)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.req_i   = 1'b1;
    bus.we_i    = 1'b1;
    bus.addr_i  = a;
    bus.wdata_i = d;
    bus.be_i    = be;
    @(negedge clk);
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.be_i    = 4'h0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = a;
    @(negedge clk);
    bus.req_i  = 1'b0;
    d = bus.rdata_o;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rv;
    int j;
    int first_rise;

    rst = 1'b1;
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.be_i = 4'h0;
    bus.addr_i = 32'h0; bus.wdata_i = 32'h0; bus.int_fin_i = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset values and readback
    check_val("rst_int_req", {31'h0, bus.int_req_o}, 32'h0);
    check_val("rst_rdata", bus.rdata_o, 32'h0);
    for (int k = 0; k < 8; k++) begin
      bus_rd(32'(k * 4), rv);
      check_val($sformatf("rst_rd_%0h", k * 4), rv, (k == 2) ? 32'hFFFF_FFFF : 32'h0);
    end
    bus_wr(32'h0C, 32'h1234_5678, 4'b0101);
    bus_rd(32'h0C, rv);
    check_val("count_be0101", rv, 32'h0034_0078);
    bus_wr(32'h04, 32'hFFFF_FFFF, 4'hF);
    bus_rd(32'h04, rv);
    check_val("prescale_mask", rv, 32'h0000_FFFF);
    bus_wr(32'h00, 32'hFFFF_FFF8, 4'hF);
    bus_rd(32'h00, rv);
    check_val("ctrl_mask", rv, 32'h0);
    bus_wr(32'h14, 32'hFFFF_FFFF, 4'hF);
    bus_rd(32'h14, rv);
    check_val("unmapped_14", rv, 32'h0);

    // Periodic IRQ: (4+1)*(3+1) = 20 cycles per match
    do_reset();
    bus_wr(32'h04, 32'd3, 4'hF);
    bus_wr(32'h08, 32'd4, 4'hF);
    bus_wr(32'h00, 32'h7, 4'hF);
    j = 0;
    while (!bus.int_req_o && j < 100) begin @(negedge clk); j++; end
    check_val("periodic_first_rise", 32'(j), 32'd20);
    first_rise = j;
    bus.int_fin_i = 1'b1;
    @(negedge clk); j++;
    bus.int_fin_i = 1'b0;
    check_val("periodic_fall", {31'h0, bus.int_req_o}, 32'h0);
    while (!bus.int_req_o && j < 200) begin @(negedge clk); j++; end
    check_val("periodic_period", 32'(j - first_rise), 32'd20);

    // Free run across the 32-bit wrap, no interrupt enable
    do_reset();
    bus_wr(32'h0C, 32'hFFFF_FFFE, 4'hF);
    bus_wr(32'h00, 32'h1, 4'hF);
    bus_rd(32'h0C, rv);
    check_val("wrap_cnt0", rv, 32'hFFFF_FFFE);
    bus_rd(32'h0C, rv);
    check_val("wrap_cnt1", rv, 32'hFFFF_FFFF);
    bus_rd(32'h0C, rv);
    check_val("wrap_cnt2", rv, 32'h0);
    bus_rd(32'h10, rv);
    check_val("wrap_status", rv, 32'h1);
    repeat (5) @(negedge clk);
    check_val("wrap_no_irq", {31'h0, bus.int_req_o}, 32'h0);

    // Overrun: match every 2 cycles, never finished
    do_reset();
    bus_wr(32'h08, 32'd1, 4'hF);
    bus_wr(32'h00, 32'h7, 4'hF);
    repeat (10) @(negedge clk);
    check_val("ovr_int_req", {31'h0, bus.int_req_o}, 32'h1);
    bus_rd(32'h10, rv);
    check_val("ovr_status", rv, 32'h7);
    bus_wr(32'h00, 32'h6, 4'hF);
    bus_wr(32'h10, 32'h5, 4'b1110);
    bus_rd(32'h10, rv);
    check_val("ovr_w1c_no_be0", rv, 32'h7);
    bus_wr(32'h10, 32'h5, 4'b0001);
    bus_rd(32'h10, rv);
    check_val("ovr_w1c", rv, 32'h2);
    check_val("ovr_still_req", {31'h0, bus.int_req_o}, 32'h1);

    // Asynchronous reset while a request is pending
    #2 rst = 1'b1;
    #1 check_val("async_rst_int_req", {31'h0, bus.int_req_o}, 32'h0);
    check_val("async_rst_rdata", bus.rdata_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_rd(32'h00, rv);
    check_val("async_rst_ctrl", rv, 32'h0);
    bus_rd(32'h08, rv);
    check_val("async_rst_compare", rv, 32'hFFFF_FFFF);
    bus_rd(32'h0C, rv);
    check_val("async_rst_count", rv, 32'h0);
    bus_rd(32'h10, rv);
    check_val("async_rst_status", rv, 32'h0);

    // Finish pulse coinciding with a new match: int_req goes 1,0,1
    do_reset();
    bus_wr(32'h08, 32'd1, 4'hF);
    bus_wr(32'h00, 32'h7, 4'hF);
    repeat (3) @(negedge clk);
    check_val("coll_req_before", {31'h0, bus.int_req_o}, 32'h1);
    bus.int_fin_i = 1'b1;
    @(negedge clk);
    bus.int_fin_i = 1'b0;
    check_val("coll_req_gap", {31'h0, bus.int_req_o}, 32'h0);
    @(negedge clk);
    check_val("coll_req_again", {31'h0, bus.int_req_o}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
